// File: rtl/approx_accum.sv
// Frame accumulator with exact or lower-bit-OR approximate addition.
// It returns the frame sum, a sticky carry-out flag and a saturating beat count.
module approx_accum #(
    parameter int unsigned BWOP  = 32,
    parameter int unsigned LOWOR = 8,
    parameter int unsigned BWCNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_approx,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BWOP-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BWOP-1:0]  out_data,
    output logic             out_ovf,
    output logic [BWCNT-1:0] out_count
);

    typedef enum logic {StAcc, StHold} state_e;

    state_e           state_q, state_d;
    logic             start_q;
    logic [BWOP-1:0]  acc_q;
    logic             ovf_q;
    logic [BWCNT-1:0] cnt_q;
    logic             mode_q;

    logic             accept;
    logic [BWOP-1:0]  acc_base;
    logic             ovf_base;
    logic [BWCNT-1:0] cnt_base;
    logic [BWCNT-1:0] cnt_next;
    logic             mode_eff;
    logic [BWOP-1:0]  exact_sum;
    logic             exact_c;
    logic [BWOP-1:0]  approx_sum;
    logic             approx_c;
    logic [BWOP-1:0]  acc_next;
    logic             carry;

    assign accept = in_valid & in_ready;

    // The first beat of a frame folds into a cleared accumulator and latches the mode.
    assign acc_base = start_q ? '0 : acc_q;
    assign ovf_base = start_q ? 1'b0 : ovf_q;
    assign cnt_base = start_q ? '0 : cnt_q;
    assign mode_eff = start_q ? cfg_approx : mode_q;

    assign cnt_next = (cnt_base == {BWCNT{1'b1}}) ? cnt_base : cnt_base + BWCNT'(1);

    assign {exact_c, exact_sum} = {1'b0, acc_base} + {1'b0, in_data};

    generate
        if (LOWOR == 0) begin : g_no_or
            assign approx_sum = exact_sum;
            assign approx_c   = exact_c;
        end else begin : g_lower_or
            logic [LOWOR-1:0]    lo;
            logic                cin;
            logic [BWOP-LOWOR:0] hi;

            assign lo  = acc_base[LOWOR-1:0] | in_data[LOWOR-1:0];
            assign cin = acc_base[LOWOR-1] & in_data[LOWOR-1];
            assign hi  = {1'b0, acc_base[BWOP-1:LOWOR]} + {1'b0, in_data[BWOP-1:LOWOR]}
                       + {{(BWOP-LOWOR){1'b0}}, cin};
            assign approx_sum = {hi[BWOP-LOWOR-1:0], lo};
            assign approx_c   = hi[BWOP-LOWOR];
        end
    endgenerate

    assign acc_next = mode_eff ? approx_sum : exact_sum;
    assign carry    = mode_eff ? approx_c : exact_c;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StAcc: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcc;
            start_q <= 1'b1;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                start_q <= 1'b0;
                acc_q   <= acc_next;
                ovf_q   <= ovf_base | carry;
                cnt_q   <= cnt_next;
                mode_q  <= mode_eff;
            end
            if (out_valid && out_ready) begin
                start_q <= 1'b1;
            end
        end
    end

    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_approx_accum.sv
// Directed bench for approx_accum: two instances (BWCNT=16 and BWCNT=2) share the same stimulus.
module tb_approx_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_approx = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf;
    logic [7:0]  out_data;
    logic [15:0] out_count;
    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [7:0]  s_out_data;
    logic [1:0]  s_out_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    approx_accum #(.BWOP(8), .LOWOR(4), .BWCNT(16)) dut (
        .clk(clk), .rst(rst), .cfg_approx(cfg_approx),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_count(out_count)
    );

    approx_accum #(.BWOP(8), .LOWOR(4), .BWCNT(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_approx(cfg_approx),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_ovf(s_out_ovf), .out_count(s_out_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic o,
                                input logic [15:0] c);
        check({tag, " valid"}, out_valid, 1'b1);
        check({tag, " data"}, out_data, d);
        check({tag, " ovf"}, out_ovf, o);
        check({tag, " count"}, out_count, c);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_data", out_data, 8'h00);
        check("rst out_ovf", out_ovf, 1'b0);
        check("rst out_count", out_count, 16'd0);

        // Exact mode, latency 1
        cfg_approx = 1'b0;
        beat(8'h10, 1'b0);
        beat(8'h20, 1'b0);
        check("exact mid valid", out_valid, 1'b0);
        check("exact mid running", out_data, 8'h30);
        beat(8'h30, 1'b1);
        check_result("exact", 8'h60, 1'b0, 16'd3);

        // Backpressure: beats offered while holding are ignored
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp in_ready", in_ready, 1'b0);
            check("bp data", out_data, 8'h60);
            check("bp count", out_count, 16'd3);
            check("bp valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handoff();
        check("bp release in_ready", in_ready, 1'b1);
        check("bp release valid", out_valid, 1'b0);

        // Approximate mode
        cfg_approx = 1'b1;
        beat(8'h08, 1'b0);
        beat(8'h08, 1'b1);
        check_result("approx 08+08", 8'h18, 1'b0, 16'd2);
        handoff();
        beat(8'h0F, 1'b0);
        cfg_approx = 1'b0;  // mid-frame change must be ignored (exact would give 0x10)
        beat(8'h01, 1'b1);
        check_result("approx 0F+01", 8'h0F, 1'b0, 16'd2);
        handoff();
        cfg_approx = 1'b1;
        beat(8'hF8, 1'b0);
        beat(8'h08, 1'b1);
        check_result("approx ovf", 8'h08, 1'b1, 16'd2);
        handoff();

        // Exact-mode overflow, cleared at next frame
        cfg_approx = 1'b0;
        beat(8'hF0, 1'b0);
        beat(8'h20, 1'b1);
        check_result("exact ovf", 8'h10, 1'b1, 16'd2);
        handoff();
        beat(8'h01, 1'b1);
        check_result("single beat", 8'h01, 1'b0, 16'd1);
        handoff();

        // Reset mid-frame
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        check("pre-rst running", out_data, 8'h07);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst valid", out_valid, 1'b0);
        check("mid rst data", out_data, 8'h00);
        check("mid rst count", out_count, 16'd0);
        beat(8'h05, 1'b1);
        check_result("after rst", 8'h05, 1'b0, 16'd1);

        // Reset while holding a result
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hold rst valid", out_valid, 1'b0);
        check("hold rst in_ready", in_ready, 1'b1);
        check("hold rst data", out_data, 8'h00);

        // Count saturation on the BWCNT=2 instance
        for (int i = 0; i < 4; i++) beat(8'h01, 1'b0);
        beat(8'h01, 1'b1);
        check("sat valid", s_out_valid, 1'b1);
        check("sat count", s_out_count, 2'd3);
        check("sat data", s_out_data, 8'h05);
        check("wide count", out_count, 16'd5);
        handoff();
        check("sat release in_ready", s_in_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/approx_accum.md
APPROX_ACCUM -- requirements
Module: approx_accum

Interface
REQ-001 SHALL have parameter BWOP, default 32: operand and accumulator width in bits, legal range 4..64.
REQ-002 SHALL have parameter LOWOR, default 8: number of low bits computed by OR in approximate mode, legal range 0..BWOP-1.
REQ-003 SHALL have parameter BWCNT, default 16: beat-counter width in bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge; one clock, reset synchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port cfg_approx, input, 1 bit: 1 selects lower-bit-OR mode, 0 selects exact add; sampled on a frame's first accepted beat.
REQ-007 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept a beat.
REQ-009 SHALL have port in_data, input, BWOP bits: operand.
REQ-010 SHALL have port in_last, input, 1 bit: marks the final beat of a frame.
REQ-011 SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port out_data, output, BWOP bits: frame sum, modulo 2^BWOP.
REQ-014 SHALL have port out_ovf, output, 1 bit: sticky carry-out seen during the frame.
REQ-015 SHALL have port out_count, output, BWCNT bits: beats in the frame, saturating.

Function
REQ-016 SHALL implement two states, ACC and HOLD: in ACC, in_ready=1 and out_valid=0; in HOLD, in_ready=0 and out_valid=1.
REQ-017 SHALL accept a beat only when in_valid and in_ready are both 1 at a rising edge.
REQ-018 SHALL treat the first accepted beat after reset or after a result handoff as frame start: accumulator starts from 0, ovf cleared, count=1, mode latched from cfg_approx.
REQ-019 SHALL update on each accepted beat as acc <= F(acc, in_data), where F is the mode's add truncated to BWOP bits.
REQ-020 SHALL compute exact-mode F as acc + in_data, with carry-out = bit BWOP of the full sum.
REQ-021 SHALL compute approximate-mode F as follows, with LOWOR=0 making it identical to exact mode:
- low LOWOR bits = acc | in_data;
- upper BWOP-LOWOR bits = acc_hi + d_hi + cin, where cin = acc[LOWOR-1] & in_data[LOWOR-1];
- carry-out = carry out of the upper add.
REQ-022 SHALL set ovf if any accepted beat of the frame produces carry-out, and hold it until the next frame start.
REQ-023 SHALL increment count on each accepted beat and saturate at 2^BWCNT-1 without wrapping.
REQ-024 SHALL, on accepting a beat with in_last=1, fold that beat in and enter HOLD on the same edge, so out_valid rises the cycle after the last beat (latency 1).
REQ-025 SHALL hold out_data, out_ovf and out_count stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on out_valid & out_ready, return to ACC on that edge; the next accepted beat starts a new frame.
REQ-027 SHALL ignore changes to cfg_approx mid-frame.
REQ-028 SHALL treat a frame consisting of a single beat with in_last=1 as valid: out_data=in_data, ovf=0, count=1.
REQ-029 SHALL let out_* reflect the running value while in ACC; only out_valid qualifies them.

Reset
REQ-030 SHALL, when rst=1 at a rising edge, force state=ACC, acc=0, ovf=0, count=0 and latched mode=exact, regardless of current state.
REQ-031 SHALL drive out_valid=0, in_ready=1, out_data=0, out_ovf=0 and out_count=0 in the cycle after reset.
REQ-032 SHALL discard any partial frame or held result on reset, and treat the first beat after reset as frame start.

Verification
REQ-033 SHALL cover exact mode, BWOP=8, LOWOR=4: beats 0x10, 0x20, 0x30 (last) -> out_data=0x60, ovf=0, count=3, out_valid one cycle after the last beat.
REQ-034 SHALL cover approximate mode, BWOP=8, LOWOR=4:
- beats 0x08, 0x08 (last) -> out_data=0x18;
- beats 0x0F, 0x01 (last) -> out_data=0x0F.
REQ-035 SHALL cover exact-mode overflow: beats 0xF0, 0x20 (last) -> out_data=0x10, ovf=1, count=2; the next frame 0x01 (last) -> ovf=0.
REQ-036 SHALL cover backpressure: out_ready=0 for 3 cycles after the result -> out_* stable, in_ready=0, in_valid beats not accepted; out_ready=1 -> in_ready=1 the next cycle.
REQ-037 SHALL cover reset mid-frame: 2 beats accepted, then rst pulsed -> out_valid=0 and out_data=0; a subsequent 0x05 (last) -> out_data=0x05, count=1.
REQ-038 SHALL cover count saturation with BWCNT=2: 5 beats of 0x01 -> out_count=3, out_data=0x05.
